// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache between the CPU data port
// and memory port 2; fills lines word by word and keeps saturating hit/miss statistics.
module dcache_controller #(
   parameter int unsigned WORD_SIZE   = 16,
   parameter int unsigned LINE_WORDS  = 4,
   parameter int unsigned NUM_LINES   = 4,
   parameter int unsigned MEM_LATENCY = 3,
   parameter logic [15:0] COUNT_INIT  = '0  // reset value of both statistic counters
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cpu_read,
   input  logic                 cpu_write,
   input  logic [WORD_SIZE-1:0] cpu_address,
   input  logic [WORD_SIZE-1:0] cpu_wdata,
   output logic [WORD_SIZE-1:0] cpu_rdata,
   output logic                 cpu_ready,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic [WORD_SIZE-1:0] mem_address,
   inout  wire  [WORD_SIZE-1:0] mem_data,
   output logic [15:0]          hit_count,
   output logic [15:0]          miss_count
);
   localparam int unsigned OFF_W = $clog2(LINE_WORDS);
   localparam int unsigned IDX_W = $clog2(NUM_LINES);
   localparam int unsigned TAG_W = WORD_SIZE - OFF_W - IDX_W;
   localparam int unsigned LAT_W = $clog2(MEM_LATENCY + 1);
   localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(MEM_LATENCY - 1);
   localparam logic [LAT_W-1:0] LAT_GAP   = LAT_W'(MEM_LATENCY);
   localparam logic [OFF_W-1:0] WORD_LAST = OFF_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

   state_t                 state_q;
   logic [WORD_SIZE-1:0]   data_q [NUM_LINES][LINE_WORDS];
   logic [TAG_W-1:0]       tag_q  [NUM_LINES];
   logic [NUM_LINES-1:0]   valid_q;
   logic [OFF_W-1:0]       word_q;
   logic [LAT_W-1:0]       lat_q;
   logic [WORD_SIZE-1:0]   wdata_q;
   logic [WORD_SIZE-1:0]   rdata_q;
   logic [WORD_SIZE-1:0]   mem_addr_q;
   logic                   ready_q;
   logic                   mem_read_q;
   logic                   mem_write_q;
   logic [15:0]            hit_q;
   logic [15:0]            miss_q;

   logic [OFF_W-1:0]       req_off;
   logic [IDX_W-1:0]       req_idx;
   logic [TAG_W-1:0]       req_tag;
   logic                   req_hit;

   // The CPU holds its request until cpu_ready, so the fill reuses the live address.
   assign req_off = cpu_address[OFF_W-1:0];
   assign req_idx = cpu_address[OFF_W +: IDX_W];
   assign req_tag = cpu_address[WORD_SIZE-1 -: TAG_W];
   assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         word_q      <= '0;
         lat_q       <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         mem_addr_q  <= '0;
         ready_q     <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         hit_q       <= COUNT_INIT;
         miss_q      <= COUNT_INIT;
         for (int unsigned l = 0; l < NUM_LINES; l++) begin
            tag_q[l] <= '0;
            for (int unsigned w = 0; w < LINE_WORDS; w++) data_q[l][w] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               lat_q  <= '0;
               word_q <= '0;
               if (cpu_write) begin
                  mem_write_q <= 1'b1;
                  mem_addr_q  <= cpu_address;
                  wdata_q     <= cpu_wdata;
                  state_q     <= WRITE;
                  if (req_hit) begin
                     hit_q                      <= sat_inc(hit_q);
                     data_q[req_idx][req_off] <= cpu_wdata;
                  end else begin
                     miss_q <= sat_inc(miss_q);
                  end
               end else if (cpu_read) begin
                  if (req_hit) begin
                     rdata_q <= data_q[req_idx][req_off];
                     ready_q <= 1'b1;
                     hit_q   <= sat_inc(hit_q);
                     state_q <= RESP;
                  end else begin
                     miss_q           <= sat_inc(miss_q);
                     valid_q[req_idx] <= 1'b0;
                     mem_read_q       <= 1'b1;
                     mem_addr_q       <= {req_tag, req_idx, OFF_W'(0)};
                     state_q          <= FILL;
                  end
               end
            end
            FILL: begin
               // lat_q counts the strobe cycles, then one extra value marks the idle gap
               if (lat_q == LAT_GAP) begin
                  lat_q <= '0;
                  if (word_q == WORD_LAST) begin
                     tag_q[req_idx]   <= req_tag;
                     valid_q[req_idx] <= 1'b1;
                     rdata_q          <= data_q[req_idx][req_off];
                     ready_q          <= 1'b1;
                     state_q          <= RESP;
                  end else begin
                     word_q     <= word_q + OFF_W'(1);
                     mem_read_q <= 1'b1;
                     mem_addr_q <= {req_tag, req_idx, word_q + OFF_W'(1)};
                  end
               end else begin
                  lat_q <= lat_q + LAT_W'(1);
                  if (lat_q == LAT_LAST) begin
                     data_q[req_idx][word_q] <= mem_data;
                     mem_read_q              <= 1'b0;
                  end
               end
            end
            WRITE: begin
               if (lat_q == LAT_LAST) begin
                  mem_write_q <= 1'b0;
                  ready_q     <= 1'b1;
                  state_q     <= RESP;
               end else begin
                  lat_q <= lat_q + LAT_W'(1);
               end
            end
            RESP: begin
               ready_q <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cpu_rdata   = rdata_q;
   assign cpu_ready   = ready_q;
   assign mem_read    = mem_read_q;
   assign mem_write   = mem_write_q;
   assign mem_address = mem_addr_q;
   assign mem_data    = mem_write_q ? wdata_q : {WORD_SIZE{1'bz}};
   assign hit_count   = hit_q;
   assign miss_count  = miss_q;
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: main instance with a latency-accurate memory model,
// plus a second instance whose counters start near saturation.
module tb_dcache_controller;
   localparam int MEM_LATENCY = 3;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        cpu_read = 1'b0;
   logic        cpu_write = 1'b0;
   logic [15:0] cpu_address = '0;
   logic [15:0] cpu_wdata = '0;

   logic [15:0] cpu_rdata, mem_address, hit_count, miss_count;
   logic        cpu_ready, mem_read, mem_write;
   wire  [15:0] mem_data;

   logic [15:0] rdata1, mem_address1, hit1, miss1;
   logic        ready1, mem_read1, mem_write1;
   wire  [15:0] mem_data1;

   int          n_cmp = 0;
   int          n_fail = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          proto_err = 0;
   logic [15:0] rd_log[$];
   logic [31:0] wr_log[$];

   always #5 clk = ~clk;

   dcache_controller u_dut (
      .clk(clk), .reset_n(reset_n), .cpu_read(cpu_read), .cpu_write(cpu_write),
      .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_ready(cpu_ready), .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_data(mem_data), .hit_count(hit_count),
      .miss_count(miss_count)
   );

   dcache_controller #(.COUNT_INIT(16'hFFFE)) u_sat (
      .clk(clk), .reset_n(reset_n), .cpu_read(cpu_read), .cpu_write(cpu_write),
      .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata1),
      .cpu_ready(ready1), .mem_read(mem_read1), .mem_write(mem_write1),
      .mem_address(mem_address1), .mem_data(mem_data1), .hit_count(hit1),
      .miss_count(miss1)
   );

   // Valid data only in the last strobe cycle; a garbage word before that.
   assign mem_data  = mem_read ? ((rd_cnt == MEM_LATENCY - 1) ? (mem_address ^ 16'hA5A5) : 16'hDEAD)
                               : 16'hzzzz;
   assign mem_data1 = mem_read1 ? (mem_address1 ^ 16'hA5A5) : 16'hzzzz;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_cnt <= 0;
         wr_cnt <= 0;
      end else begin
         if ((mem_read && mem_write) || (mem_read1 && mem_write1) ||
             (mem_read && rd_cnt >= MEM_LATENCY) || (mem_write && wr_cnt >= MEM_LATENCY) ||
             (!mem_read && rd_cnt != 0 && rd_cnt != MEM_LATENCY) ||
             (!mem_write && wr_cnt != 0 && wr_cnt != MEM_LATENCY))
            proto_err <= proto_err + 1;
         if (mem_read && rd_cnt == MEM_LATENCY - 1) rd_log.push_back(mem_address);
         if (mem_write && wr_cnt == MEM_LATENCY - 1) wr_log.push_back({mem_address, mem_data});
         rd_cnt <= mem_read ? rd_cnt + 1 : 0;
         wr_cnt <= mem_write ? wr_cnt + 1 : 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                      output int cycles, output logic [15:0] rd, output logic [15:0] rd1);
      @(negedge clk);
      rd_log.delete();
      wr_log.delete();
      cpu_read = ~wr; cpu_write = wr; cpu_address = addr; cpu_wdata = wd;
      cycles = 0; rd = '0; rd1 = '0;
      for (int n = 1; n <= 64; n++) begin
         @(posedge clk); #1;
         if (cpu_ready) begin
            cycles = n; rd = cpu_rdata; rd1 = rdata1;
            break;
         end
      end
      chk("ready_sat_inst", 32'(ready1), 1);
      cpu_read = 1'b0; cpu_write = 1'b0;
      @(posedge clk); #1;
      chk("ready_pulse", 32'(cpu_ready), 0);
   endtask

   task automatic read_chk(input string tag, input logic [15:0] addr, input int exp_cyc,
                           input logic [15:0] exp_data);
      int cyc; logic [15:0] rd, rd1;
      req(1'b0, addr, '0, cyc, rd, rd1);
      chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, "_rdata"}, 32'(rd), 32'(exp_data));
      chk({tag, "_rdata_sat"}, 32'(rd1), 32'(exp_data));
   endtask

   task automatic write_chk(input string tag, input logic [15:0] addr, input logic [15:0] data);
      int cyc; logic [15:0] rd, rd1;
      req(1'b1, addr, data, cyc, rd, rd1);
      chk({tag, "_cycles"}, 32'(cyc), 4);
      chk({tag, "_wlog_n"}, 32'(wr_log.size()), 1);
      chk({tag, "_wlog"}, (wr_log.size() > 0) ? wr_log[0] : 32'hFFFF_FFFF, {addr, data});
   endtask

   task automatic fill_chk(input string tag, input logic [15:0] base);
      chk({tag, "_fill_n"}, 32'(rd_log.size()), 4);
      for (int i = 0; i < 4; i++)
         chk({tag, "_fill_addr"}, (i < rd_log.size()) ? 32'(rd_log[i]) : 32'hFFFF_FFFF,
             32'(base + 16'(i)));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #2 reset_n = 1'b0;
      #1;
      chk("rst_ready", 32'(cpu_ready), 0);
      chk("rst_mem_read", 32'(mem_read), 0);
      chk("rst_mem_write", 32'(mem_write), 0);
      chk("rst_mem_addr", 32'(mem_address), 0);
      chk("rst_rdata", 32'(cpu_rdata), 0);
      chk("rst_hits", 32'(hit_count), 0);
      chk("rst_misses", 32'(miss_count), 0);
      chk("rst_sat_hits", 32'(hit1), 'hFFFE);
      chk("rst_sat_misses", 32'(miss1), 'hFFFE);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Reset in the middle of a fill
      @(negedge clk);
      cpu_read = 1'b1; cpu_address = 16'h0021;
      repeat (6) @(posedge clk);
      #1;
      chk("t1_fill_rd", 32'(mem_read), 1);
      chk("t1_fill_addr", 32'(mem_address), 'h0021);
      chk("t1_miss_pre", 32'(miss_count), 1);
      #2 reset_n = 1'b0;
      #1;
      chk("t1_abort_rd", 32'(mem_read), 0);
      chk("t1_abort_addr", 32'(mem_address), 0);
      chk("t1_abort_miss", 32'(miss_count), 0);
      cpu_read = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      read_chk("t1_reread", 16'h0021, 17, 16'hA584);
      chk("t1_misses", 32'(miss_count), 1);
      chk("t1_hits", 32'(hit_count), 0);
      @(negedge clk); reset_n = 1'b0;
      @(negedge clk); reset_n = 1'b1;

      // Cold read miss
      read_chk("t2", 16'h0023, 17, 16'hA586);
      fill_chk("t2", 16'h0020);
      chk("t2_misses", 32'(miss_count), 1);
      chk("t2_hits", 32'(hit_count), 0);
      chk("t2_sat_misses", 32'(miss1), 'hFFFF);
      chk("t2_sat_hits", 32'(hit1), 'hFFFE);

      // Read hit
      read_chk("t3", 16'h0021, 1, 16'hA584);
      chk("t3_no_fill", 32'(rd_log.size()), 0);
      chk("t3_hits", 32'(hit_count), 1);

      // Write hit, then read back from the cache
      write_chk("t4_wr", 16'h0022, 16'h1234);
      chk("t4_hits", 32'(hit_count), 2);
      read_chk("t4_rd", 16'h0022, 1, 16'h1234);
      chk("t4_hits_rd", 32'(hit_count), 3);

      // Conflict on index 0
      read_chk("t5_a", 16'h0063, 17, 16'hA5C6);
      fill_chk("t5_a", 16'h0060);
      chk("t5_misses_a", 32'(miss_count), 2);
      read_chk("t5_b", 16'h0023, 17, 16'hA586);
      fill_chk("t5_b", 16'h0020);
      chk("t5_misses_b", 32'(miss_count), 3);

      // Write miss does not allocate
      write_chk("t6_wr", 16'h0050, 16'hBEEF);
      chk("t6_misses_wr", 32'(miss_count), 4);
      read_chk("t6_rd", 16'h0050, 17, 16'hA5F5);
      chk("t6_misses_rd", 32'(miss_count), 5);
      chk("t6_hits", 32'(hit_count), 3);

      // Saturation on the preloaded instance
      chk("sat_hits", 32'(hit1), 'hFFFF);
      chk("sat_misses", 32'(miss1), 'hFFFF);
      chk("protocol", 32'(proto_err), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the CPU data port and the data port of the multi-cycle Memory (read_m2/write_m2/address2/data2).
- Acts as the initiator on the memory port: it fills lines word by word and forwards writes.
- Returns 1-cycle hits to the CPU.
- Keeps hit and miss statistics for the lab's performance report.

Parameters:
WORD_SIZE, 16, data and address width in bits
LINE_WORDS, 4, words per line (power of 2); offset = address[1:0]
NUM_LINES, 4, lines (power of 2); index = address[3:2], tag = address[15:4]
MEM_LATENCY, 3, cycles mem_read/mem_write is held per word access

Ports:
clk  input  1  clock, all state on posedge
reset_n  input  1  asynchronous active-low reset
cpu_read  input  1  read request; held until cpu_ready
cpu_write  input  1  write request; held until cpu_ready
cpu_address  input  16  word address
cpu_wdata  input  16  write data
cpu_rdata  output  16  read data, valid while cpu_ready is high
cpu_ready  output  1  one-cycle completion pulse
mem_read  output  1  read strobe to memory port 2
mem_write  output  1  write strobe to memory port 2
mem_address  output  16  address to memory port 2
mem_data  inout  16  driven with write data only while mem_write is high, else 16'bz
hit_count  output  16  saturating hit counter
miss_count  output  16  saturating miss counter

Behaviour:
- Reset (async, reset_n low): all valid bits cleared; state = IDLE; cpu_ready, mem_read, mem_write = 0; mem_address, cpu_rdata, hit_count, miss_count = 0; mem_data = Z.
- Reset asserted mid-fill or mid-write aborts the operation immediately. The partial line is not marked valid.
- States: IDLE, FILL, WRITE, RESP.
- IDLE: request sampled on the posedge (cpu_write wins if both are high).
  - Read hit: latch the line word into cpu_rdata, hit_count+1, go to RESP.
  - Read miss: miss_count+1, clear the line's valid bit, go to FILL with word counter = 0.
  - Write, hit or miss: go to WRITE. Hit → hit_count+1 and the line word is updated on this edge. Miss → miss_count+1 and the line is unchanged.
- FILL, per word i (i = 0..LINE_WORDS-1):
  - mem_address = {tag, index, i}, with mem_read high for MEM_LATENCY cycles.
  - mem_data is sampled into line word i on the edge ending the last of those cycles.
  - One idle gap cycle follows with mem_read low.
  - After the gap of the last word: set the tag, set valid, latch the requested word into cpu_rdata, go to RESP.
  - Fill order is always 0..LINE_WORDS-1; there is no critical-word-first.
- WRITE: mem_address = cpu_address and mem_data = cpu_wdata, with mem_write high for MEM_LATENCY cycles, then go to RESP.
- RESP: cpu_ready high for exactly one cycle, then IDLE. The CPU deasserts its request on that edge. A request still high in IDLE is treated as a new request.
- Latency, with the request first sampled at edge 0:
  - Read hit: ready in cycle 1.
  - Read miss: ready in cycle LINE_WORDS*(MEM_LATENCY+1)+1 = 17.
  - Write: ready in cycle MEM_LATENCY+1 = 4.
- Counters count once per request and saturate at 16'hFFFF (no wrap).
- mem_read and mem_write are never high together; both are low in IDLE and RESP.

Test Plan:
The bench memory model returns data = address ^ 16'hA5A5 with latency matching MEM_LATENCY. Cycle numbers count from the request-sample edge.

1. Reset: reset_n low mid-cycle → all outputs 0 immediately and mem_data Z. Assert reset again during a FILL → mem_read drops immediately, and a following read of 0x0021 misses.
2. Cold read 0x0023 → mem_read addresses 0x20..0x23, each high 3 cycles plus a 1-cycle gap; cpu_ready in cycle 17 with cpu_rdata=0xA586; miss_count=1.
3. Read 0x0021 after test 2 → no mem_read; cpu_ready in cycle 1 with cpu_rdata=0xA584; hit_count=1.
4. Write 0x0022 data 0x1234 (hit) → mem_write high 3 cycles with address 0x0022 and mem_data 0x1234; cpu_ready in cycle 4. A following read of 0x0022 hits with cpu_rdata=0x1234.
5. Conflict: read 0x0063 (index 0, new tag) → miss that refills 0x60..0x63, cpu_rdata=0xA5C6. Re-read 0x0023 → miss again; miss_count increments both times.
6. Write miss 0x0050 data 0xBEEF → mem_write occurs and miss_count+1. A following read of 0x0050 still misses (no allocate). Also preload the counters near 0xFFFF and confirm they saturate at 0xFFFF.
